// File: rtl/disp_pkg.sv
// Shared types and constants for the 6-digit
// multiplexed 7-segment scan controller.
package disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Segment bit order: [0]=a .. [6]=g, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic [2:0] next_digit(
    input logic [2:0] d
  );
    return (d == 3'(NUM_DIGITS - 1)) ? 3'd0 : d + 3'd1;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_fnd_dec.sv
// BCD nibble to 7-segment pattern decoder.
// Non-decimal codes render as a dash.
module fnd_dec
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup, no state
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Display scan controller: per-frame snapshot,
// SHOW/BLANK digit slots, leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int P_SCAN_DIV = 50000,
  parameter int P_BLANK    = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  input  logic        i_lz_sup,
  output logic [5:0]  o_seg_enb,
  output logic        o_seg_dp,
  output logic [6:0]  o_seg,
  output logic        o_frame_start
);

  localparam int CW =
    (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
  localparam logic [CW-1:0] SHOW_LAST =
    CW'(P_SCAN_DIV - P_BLANK - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((P_BLANK > 0) ? P_BLANK - 1 : 0);
  localparam bit NO_BLANK = (P_BLANK == 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic          adv;
  logic          snap_ld;

  logic [23:0]   snap_dig_q;
  logic [5:0]    snap_dp_q;
  logic          snap_lz_q;

  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic [5:0]    lz_msk;

  logic [5:0]    enb_d, enb_q;
  logic          dp_d, dp_q;
  logic [6:0]    seg_d, seg_q;
  logic          fs_d, fs_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; adv marks a move to the next digit slot
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SHOW;
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            if (NO_BLANK) adv     = 1'b1;
            else          state_d = ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            adv     = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Slot counter, digit index and snapshot-load strobe
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d == ST_IDLE || state_d != state_q || adv)
      cnt_d = '0;
    dig_d = dig_q;
    if (state_d == ST_IDLE) dig_d = 3'd0;
    else if (adv)           dig_d = next_digit(dig_q);
    snap_ld = (state_q == ST_IDLE && state_d == ST_SHOW)
           || (adv && dig_d == 3'd0);
  end

  // Counter, digit index and frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dig_q      <= 3'd0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_lz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      if (snap_ld) begin
        snap_dig_q <= i_digits;
        snap_dp_q  <= i_dp;
        snap_lz_q  <= i_lz_sup;
      end
    end
  end

  assign cur_nib = snap_dig_q[{dig_q, 2'b00} +: 4];

  fnd_dec u_dec (
    .bcd_i (cur_nib),
    .seg_o (dec_seg)
  );

  // Digits 5..1 blank while they and all higher digits are zero
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    lz_msk  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero   = hi_zero && (snap_dig_q[i*4 +: 4] == 4'd0);
      lz_msk[i] = snap_lz_q && hi_zero;
    end
  end

  // Output decode from current state and digit slot
  always_comb begin
    enb_d = '0;
    dp_d  = 1'b0;
    seg_d = SEG_OFF;
    fs_d  = 1'b0;
    if (i_en && state_q == ST_SHOW) begin
      enb_d[dig_q] = 1'b1;
      dp_d         = snap_dp_q[dig_q];
      seg_d        = lz_msk[dig_q] ? SEG_OFF : dec_seg;
      fs_d         = (dig_q == 3'd0) && (cnt_q == '0);
    end
  end

  // Registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb_q <= '0;
      dp_q  <= 1'b0;
      seg_q <= SEG_OFF;
      fs_q  <= 1'b0;
    end else begin
      enb_q <= enb_d;
      dp_q  <= dp_d;
      seg_q <= seg_d;
      fs_q  <= fs_d;
    end
  end

  assign o_seg_enb     = enb_q;
  assign o_seg_dp      = dp_q;
  assign o_seg         = seg_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: two configurations
// checked against a frame-position reference model.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic [23:0] i_digits = '0;
  logic [5:0]  i_dp = '0;
  logic        i_lz_sup = 1'b0;

  logic [5:0] enb_a, enb_b;
  logic       dp_a, dp_b;
  logic [6:0] seg_a, seg_b;
  logic       fs_a, fs_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.P_SCAN_DIV(10), .P_BLANK(2)) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_digits      (i_digits),
    .i_dp          (i_dp),
    .i_lz_sup      (i_lz_sup),
    .o_seg_enb     (enb_a),
    .o_seg_dp      (dp_a),
    .o_seg         (seg_a),
    .o_frame_start (fs_a)
  );

  disp_scan_ctrl #(.P_SCAN_DIV(4), .P_BLANK(0)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_digits      (i_digits),
    .i_dp          (i_dp),
    .i_lz_sup      (i_lz_sup),
    .o_seg_enb     (enb_b),
    .o_seg_dp      (dp_b),
    .o_seg         (seg_b),
    .o_frame_start (fs_b)
  );

  typedef struct packed {
    logic [23:0] dig;
    logic [5:0]  dp;
    logic        lz;
  } snap_t;

  int          divs [2] = '{10, 4};
  int          blks [2] = '{2, 0};
  snap_t       cur [2];
  snap_t       nxt [2];
  logic [14:0] expv [2];
  logic [6:0]  pat [16];
  bit          active = 1'b0;
  bit          skip = 1'b0;
  int          c = 0;

  // Expected {frame_start, dp, enb, seg} at output position j
  function automatic logic [14:0] ref_out(
    input int j, input int div, input int blk,
    input snap_t s
  );
    int p, d, off;
    logic [3:0] nib;
    logic [6:0] sg;
    logic [5:0] en;
    p   = j % (6 * div);
    d   = p / div;
    off = p % div;
    if (off >= div - blk) return '0;
    nib = 4'((s.dig >> (4 * d)) & 24'hF);
    sg  = pat[nib];
    if (s.lz && d >= 1 && (s.dig >> (4 * d)) == 24'd0)
      sg = 7'h00;
    en = 6'(1 << d);
    return {(p == 0), s.dp[d], en, sg};
  endfunction

  function automatic logic [14:0] obs(input int m);
    if (m == 0) return {fs_a, dp_a, enb_a, seg_a};
    return {fs_b, dp_b, enb_b, seg_b};
  endfunction

  task automatic chk(
    input string tag, input logic [14:0] o,
    input logic [14:0] e
  );
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h t=%0t",
             tag, o, e, $time);
    end
  endtask

  // One clock: update model from inputs seen at the edge,
  // then compare both DUTs just after the edge
  task automatic step();
    int fr;
    @(posedge clk);
    if (!rst_n) begin
      active = 1'b0;
      skip   = 1'b0;
      expv[0] = '0;
      expv[1] = '0;
    end else if (!i_en) begin
      skip   = active;
      active = 1'b0;
      expv[0] = '0;
      expv[1] = '0;
    end else begin
      skip = 1'b0;
      if (!active) begin
        active = 1'b1;
        c = 0;
      end else begin
        c++;
      end
      for (int m = 0; m < 2; m++) begin
        fr = 6 * divs[m];
        if (c % fr == 0)
          nxt[m] = '{i_digits, i_dp, i_lz_sup};
        if (c == 0) begin
          expv[m] = '0;
        end else begin
          if ((c - 1) % fr == 0) cur[m] = nxt[m];
          expv[m] = ref_out(c - 1, divs[m], blks[m], cur[m]);
        end
      end
    end
    #1;
    if (!skip) begin
      chk("cfg_10_2", obs(0), expv[0]);
      chk("cfg_4_0", obs(1), expv[1]);
    end
  endtask

  // Advance until the 60-cycle frame position equals p
  task automatic run_until(input int p);
    int budget;
    budget = 200;
    while (!(active && (c % 60) == p) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_until: position %0d not reached", p);
    end
  endtask

  initial begin
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
            7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
            7'h40, 7'h40, 7'h40, 7'h40};

    // reset held, then idle
    repeat (3) step();
    rst_n = 1'b1;
    repeat (50) step();

    // basic scan
    i_en     = 1'b1;
    i_digits = 24'h123456;
    i_dp     = 6'b000100;
    repeat (130) step();

    // mid-frame change during digit 3
    run_until(33);
    i_digits = 24'h999999;
    repeat (100) step();

    // leading-zero suppression and dash
    i_lz_sup = 1'b1;
    i_digits = 24'h000A05;
    i_dp     = 6'b000000;
    repeat (130) step();
    i_digits = 24'h000000;
    repeat (130) step();

    // disable during digit 4, then re-enable
    run_until(43);
    i_en = 1'b0;
    repeat (5) step();
    i_en     = 1'b1;
    i_digits = 24'h708090;
    i_dp     = 6'b100001;
    repeat (70) step();

    // randomized inputs, occasional disable
    repeat (700) begin
      if ($urandom_range(0, 24) == 0)
        i_digits = 24'($urandom >> $urandom_range(0, 24));
      if ($urandom_range(0, 24) == 0)
        i_dp = 6'($urandom);
      if ($urandom_range(0, 39) == 0)
        i_lz_sup = ~i_lz_sup;
      if (i_en && $urandom_range(0, 99) == 0)
        i_en = 1'b0;
      else if (!i_en && $urandom_range(0, 3) == 0)
        i_en = 1'b1;
      step();
    end
    i_en = 1'b1;
    repeat (30) step();

    // asynchronous reset mid-SHOW
    run_until(25);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_a", obs(0), 15'h0);
    chk("async_rst_b", obs(1), 15'h0);
    i_en = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    i_en     = 1'b1;
    i_digits = 24'h050403;
    repeat (70) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
